// File: rtl/iter_div_pkg.sv
// Shared types for the execute-stage integer divider: operand width,
// iteration count and the RV32M divide opcode encoding (funct3[1:0]).
package iter_div_pkg;

    localparam int XLEN_WIDTH     = 32;
    localparam int DIV_ITERATIONS = XLEN_WIDTH;

    typedef logic [XLEN_WIDTH-1:0] xlen_data_t;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

endpackage

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; one operation in
// flight, operands latched as magnitudes and signs restored in FIXUP.
//
// state  | meaning
// IDLE   | ready_o high, waiting for req_i
// CALC   | one quotient bit per cycle, DIV_ITERATIONS cycles
// FIXUP  | sign correction and result select, early_wake_up_o high
// DONE   | result_valid_o high for one non-stalled cycle
module iter_div
    import iter_div_pkg::*;
#(
    parameter int XLEN_WIDTH = iter_div_pkg::XLEN_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic [XLEN_WIDTH-1:0] a_i,
    input  logic [XLEN_WIDTH-1:0] b_i,
    input  logic                  req_i,
    input  logic                  kill_i,
    input  logic [1:0]            operation_sel_i,
    output logic [XLEN_WIDTH-1:0] div_result_o,
    output logic                  ready_o,
    output logic                  result_valid_o,
    output logic                  early_wake_up_o
);

    localparam int W     = XLEN_WIDTH;
    localparam int CNT_W = $clog2(W);
    localparam logic [W-1:0]     INT_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    div_op_t          op_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic [W-1:0]     dvd_q;      // dividend in, quotient out
    logic [W-1:0]     dvs_q;
    logic [W:0]       rem_q;
    logic [W-1:0]     result_q;

    logic         signed_op;
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic         div_by_zero;
    logic         overflow;
    logic [W:0]   rem_shift;
    logic         rem_ge;
    logic [W-1:0] fix_quot;
    logic [W-1:0] fix_rem;

    assign signed_op   = ~operation_sel_i[0];
    assign a_neg       = a_i[W-1] & signed_op;
    assign b_neg       = b_i[W-1] & signed_op;
    assign a_mag       = a_neg ? (~a_i + 1'b1) : a_i;
    assign b_mag       = b_neg ? (~b_i + 1'b1) : b_i;
    assign div_by_zero = (b_i == '0);
    assign overflow    = signed_op && (a_i == INT_MIN) && (b_i == '1);

    assign rem_shift = {rem_q[W-1:0], dvd_q[W-1]};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_q});

    assign fix_quot = (a_neg_q ^ b_neg_q) ? (~dvd_q + 1'b1) : dvd_q;
    assign fix_rem  = a_neg_q ? (~rem_q[W-1:0] + 1'b1) : rem_q[W-1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= DIV;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else if (kill_i) begin
            state_q <= S_IDLE;
        end else if (!stall_i) begin
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        op_q  <= div_op_t'(operation_sel_i);
                        cnt_q <= '0;
                        // Special results are stored final, so sign fixup is disabled.
                        if (div_by_zero) begin
                            a_neg_q <= 1'b0;
                            b_neg_q <= 1'b0;
                            dvd_q   <= '1;
                            rem_q   <= {1'b0, a_i};
                            state_q <= S_FIXUP;
                        end else if (overflow) begin
                            a_neg_q <= 1'b0;
                            b_neg_q <= 1'b0;
                            dvd_q   <= INT_MIN;
                            rem_q   <= '0;
                            state_q <= S_FIXUP;
                        end else begin
                            a_neg_q <= a_neg;
                            b_neg_q <= b_neg;
                            dvd_q   <= a_mag;
                            dvs_q   <= b_mag;
                            rem_q   <= '0;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= rem_ge ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
                    dvd_q <= {dvd_q[W-2:0], rem_ge};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    result_q <= op_q[1] ? fix_rem : fix_quot;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign div_result_o    = result_q;
    assign ready_o         = (state_q == S_IDLE);
    assign early_wake_up_o = (state_q == S_FIXUP);
    assign result_valid_o  = (state_q == S_DONE);

endmodule

// File: tb/tb_iter_div.sv
// Randomized and directed checks of iter_div against an arithmetic reference
// of the RV32M divide/remainder rules.
module tb_iter_div;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        req_i;
    logic        kill_i;
    logic [1:0]  operation_sel_i;
    logic [31:0] div_result_o;
    logic        ready_o;
    logic        result_valid_o;
    logic        early_wake_up_o;

    int n_checks = 0;
    int n_pass   = 0;

    iter_div dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .req_i           (req_i),
        .kill_i          (kill_i),
        .operation_sel_i (operation_sel_i),
        .div_result_o    (div_result_o),
        .ready_o         (ready_o),
        .result_valid_o  (result_valid_o),
        .early_wake_up_o (early_wake_up_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!op[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        operation_sel_i = op;
        a_i = a;
        b_i = b;
        req_i = 1'b1;
        stall_i = 1'b0;
        step();
        req_i = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit rnd_stall);
        int cyc;
        int nst;
        int wake_cyc;
        int base;
        base = is_special(op, a, b) ? 2 : 34;
        chk("ready_before", {31'd0, ready_o}, 32'd1);
        accept(op, a, b);
        cyc = 1;
        nst = 0;
        wake_cyc = -1;
        while (!result_valid_o && cyc < 200) begin
            if (early_wake_up_o && wake_cyc < 0) wake_cyc = cyc;
            stall_i = rnd_stall && ($urandom_range(7) == 0);
            if (stall_i) nst++;
            step();
            cyc++;
        end
        stall_i = 1'b0;
        chk("latency", cyc, base + nst);
        chk("result", div_result_o, model(op, a, b));
        if (!rnd_stall) chk("wake_cycle", wake_cyc, base - 1);
        step();
        chk("ready_after", {31'd0, ready_o}, 32'd1);
        chk("valid_after", {31'd0, result_valid_o}, 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cnt;

        rst_i = 1'b0;
        stall_i = 1'b0;
        req_i = 1'b0;
        kill_i = 1'b0;
        a_i = '0;
        b_i = '0;
        operation_sel_i = 2'b00;
        #12;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_valid", {31'd0, result_valid_o}, 32'd0);
        chk("rst_wake", {31'd0, early_wake_up_o}, 32'd0);
        chk("rst_result", div_result_o, 32'd0);
        rst_i = 1'b1;
        step();

        do_op(2'b00, 32'd100, 32'd7, 1'b0);
        do_op(2'b10, 32'd100, 32'd7, 1'b0);
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(2'b01, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(2'b00, 32'd5, 32'd0, 1'b0);
        do_op(2'b11, 32'd5, 32'd0, 1'b0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0);

        // Stall 4 cycles mid-CALC and 3 cycles in DONE.
        accept(2'b00, 32'd100, 32'd7);
        for (int c = 1; c < 38; c++) begin
            stall_i = (c >= 10 && c <= 13);
            step();
        end
        stall_i = 1'b0;
        chk("stall_valid38", {31'd0, result_valid_o}, 32'd1);
        chk("stall_result", div_result_o, 32'd14);
        for (int s = 0; s < 3; s++) begin
            stall_i = 1'b1;
            step();
            chk("stall_done_valid", {31'd0, result_valid_o}, 32'd1);
            chk("stall_done_result", div_result_o, 32'd14);
        end
        stall_i = 1'b0;
        step();
        chk("stall_ready", {31'd0, ready_o}, 32'd1);

        // Request while busy is ignored.
        accept(2'b01, 32'd1000, 32'd10);
        operation_sel_i = 2'b01;
        a_i = 32'd77;
        b_i = 32'd7;
        req_i = 1'b1;
        cnt = 1;
        while (!result_valid_o && cnt < 200) begin
            step();
            cnt++;
        end
        req_i = 1'b0;
        chk("busy_req_lat", cnt, 34);
        chk("busy_req_result", div_result_o, 32'd100);
        step();

        // Kill at cycle 10 with a simultaneous request.
        accept(2'b00, 32'd1234, 32'd3);
        for (int c = 1; c < 10; c++) step();
        kill_i = 1'b1;
        req_i = 1'b1;
        operation_sel_i = 2'b00;
        a_i = 32'd9;
        b_i = 32'd0;
        step();
        kill_i = 1'b0;
        req_i = 1'b0;
        chk("kill_ready", {31'd0, ready_o}, 32'd1);
        chk("kill_wake", {31'd0, early_wake_up_o}, 32'd0);
        step();
        chk("kill_req_dropped", {31'd0, ready_o}, 32'd1);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (result_valid_o || early_wake_up_o) cnt++;
            step();
        end
        chk("kill_no_valid", cnt, 0);

        // Async reset mid-CALC.
        accept(2'b00, 32'd50, 32'd5);
        for (int c = 1; c < 6; c++) step();
        #2 rst_i = 1'b0;
        #1;
        chk("arst_ready", {31'd0, ready_o}, 32'd1);
        chk("arst_valid", {31'd0, result_valid_o}, 32'd0);
        chk("arst_wake", {31'd0, early_wake_up_o}, 32'd0);
        chk("arst_result", div_result_o, 32'd0);
        #2 rst_i = 1'b1;
        step();
        chk("arst_idle", {31'd0, ready_o}, 32'd1);

        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(3));
            a = $urandom;
            case ($urandom_range(5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(15)) + 32'd1;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = -(32'($urandom_range(100)) + 32'd1);
                4: b = $urandom >> $urandom_range(31);
                default: b = $urandom;
            endcase
            do_op(op, a, b, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
